bus_dtack_ctrl: RTL and testbench
=================================

# bus_dtack_ctrl

68000 bus-cycle controller for the cartridge/I-O side of the system bus, one stage downstream of the TMSS gate: it consumes the cart enable (CE0) that TMSS produces, decodes each 68k cycle into a region and generates DTACK after a per-region number of wait states. Unmapped or gated-off accesses are stalled and, when compiled in, released by a watchdog. All inputs are synchronous to MCLK.

## Interface
Parameters:
- ROM_WS, 0, wait states for cartridge ROM (VA[22:21]==2'b00), range 0-15
- Z80_WS, 2, wait states for Z80 space (VA[22:15]==8'hA0), range 0-15
- IO_WS, 1, wait states for I/O/control space (VA[22:15]==8'hA1), range 0-15
- RAM_WS, 0, wait states for work RAM (VA[22:20]==3'b111), range 0-15
- TIMEOUT, 127, stall cycles before watchdog release, range 1-127

Ports:
- MCLK  in  1  system clock
- SRES  in  1  synchronous reset, active-high
- AS  in  1  68k address strobe, active-low
- UDS  in  1  upper data strobe, active-low
- LDS  in  1  lower data strobe, active-low
- RW  in  1  1 = read, 0 = write
- VA  in  23  word address (A23..A1)
- CE0  in  1  cart enable from TMSS, active-low; 1 = cartridge locked out
- DTACK  out  1  data acknowledge, active-low
- cycle_active  out  1  high from qualification until cycle end
- region  out  3  latched region: 0 ROM, 1 Z80, 2 IO, 3 RAM, 7 unmapped
- timeout  out  1  one-cycle pulse on watchdog release

## Operation
- States: IDLE, WAIT, ACK, STALL.
- IDLE: qualifying edge = AS==0 and (UDS==0 or LDS==0). On it latch region from VA; ROM counts as unmapped when CE0==1. Mapped: load 4-bit wait counter with region's WS, go WAIT. Unmapped: clear 7-bit stall counter, go STALL. cycle_active=1.
- Writes qualify only once a data strobe is low (68k asserts write strobes one clock after AS); AS low with both strobes high stays in IDLE.
- WAIT: counter==0 -> ACK, DTACK driven 0; else decrement.
- ACK: DTACK held 0 while AS==0. AS sampled 1 -> IDLE, DTACK=1, cycle_active=0 at that edge.
- STALL: DTACK held 1; behaviour per Configuration.
- Abort: AS sampled 1 in WAIT or STALL -> IDLE, no DTACK, no timeout pulse.
- region holds its value after the cycle until next qualification; 0 after reset.
- Counters never wrap: wait counter stops at 0; stall counter saturates at TIMEOUT.
- SRES wins over everything: any state -> IDLE same edge.

## Timing
- Reset values: DTACK=1, cycle_active=0, region=0, timeout=0, state IDLE, counters 0.
- All outputs registered; change only on MCLK rising edge.
- Qualifying edge E0; DTACK first low after edge E(WS+1) (WS=0 -> low after E1).
- DTACK release: same edge that samples AS==1; zero extra cycles.
- Back-to-back: AS high for one sample then low with strobe -> new qualification at the next edge; no dead cycle required.
- CE0 and VA sampled only at the qualifying edge; later changes do not affect the running cycle.
- Watchdog (when enabled): timeout pulse and DTACK=0 after edge E0+TIMEOUT+1.

## Configuration
- BUS_TIMEOUT_EN defined: STALL increments stall counter each cycle; at TIMEOUT, pulse timeout for one cycle and go ACK (DTACK=0, bus released normally by AS rising).
- BUS_TIMEOUT_EN undefined: no stall counter; STALL holds DTACK=1 until AS==1 or SRES; timeout tied 0.

## Test plan
- ROM read, VA=23'h000100, CE0=0, AS/UDS/LDS low at E0, ROM_WS=0 -> region=0, DTACK low after E1, high on edge sampling AS=1.
- IO write, VA=23'h508000 (A10000), AS low one cycle before LDS -> qualification on LDS edge, DTACK low IO_WS+1=2 edges later.
- ROM read with CE0=1 -> region=7, DTACK stays 1; with BUS_TIMEOUT_EN, timeout pulse and DTACK low after E0+128; without, DTACK 1 until AS rises.
- Z80 read aborted: AS rises after E1 (Z80_WS=2) -> IDLE, DTACK never low, timeout=0.
- SRES asserted while in ACK -> next edge DTACK=1, cycle_active=0, region=0, state IDLE.
- Back-to-back RAM reads, VA=23'h7F8000, AS high one sample between -> two DTACK pulses, second low 1 edge after its qualification.

Source files
------------

// File: rtl/bus_dtack_ctrl.sv
// bus_dtack_ctrl: 68000 bus-cycle controller for the cartridge / I-O side.
// Each qualified 68k cycle is decoded into a region. Mapped regions get DTACK
// after that region's wait-state count. Unmapped regions, and ROM while TMSS
// holds CE0 high, are stalled.
// Optional feature macro: BUS_TIMEOUT_EN. When defined, a watchdog releases a
// stalled cycle after TIMEOUT cycles and pulses timeout. When undefined, a
// stalled cycle waits for AS to rise and timeout is tied low.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no cycle in progress, waiting for AS low plus a data strobe
// ST_WAIT  | mapped cycle, counting down wait states
// ST_ACK   | DTACK asserted, waiting for AS to rise
// ST_STALL | unmapped or locked-out cycle, DTACK held high

module bus_dtack_ctrl #(
    parameter int unsigned ROM_WS  = 0,
    parameter int unsigned Z80_WS  = 2,
    parameter int unsigned IO_WS   = 1,
    parameter int unsigned RAM_WS  = 0,
    parameter int unsigned TIMEOUT = 127
) (
    input  logic        MCLK,
    input  logic        SRES,
    input  logic        AS,
    input  logic        UDS,
    input  logic        LDS,
    input  logic        RW,
    input  logic [22:0] VA,
    input  logic        CE0,
    output logic        DTACK,
    output logic        cycle_active,
    output logic [2:0]  region,
    output logic        timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ACK   = 2'd2,
        ST_STALL = 2'd3
    } state_t;

    localparam logic [2:0] REG_ROM      = 3'd0;
    localparam logic [2:0] REG_Z80      = 3'd1;
    localparam logic [2:0] REG_IO       = 3'd2;
    localparam logic [2:0] REG_RAM      = 3'd3;
    localparam logic [2:0] REG_UNMAPPED = 3'd7;

    localparam logic [3:0] ROM_WS_C = 4'(ROM_WS);
    localparam logic [3:0] Z80_WS_C = 4'(Z80_WS);
    localparam logic [3:0] IO_WS_C  = 4'(IO_WS);
    localparam logic [3:0] RAM_WS_C = 4'(RAM_WS);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        dtack_q, dtack_d;
    logic        active_q, active_d;
    logic [2:0]  region_q, region_d;
    logic        timeout_q, timeout_d;
`ifdef BUS_TIMEOUT_EN
    localparam logic [6:0] TIMEOUT_C = 7'(TIMEOUT);
    logic [6:0]  stall_cnt_q, stall_cnt_d;
`endif

    logic        qualify;
    logic [2:0]  dec_region;
    logic [3:0]  dec_ws;

    // RW and the low address bits do not influence cycle timing.
    logic        unused_inputs;
    assign unused_inputs = RW ^ (^VA[14:0]);

    // A cycle starts only once a data strobe joins AS; write strobes lag AS by a clock.
    assign qualify = !AS && (!UDS || !LDS);

    // Region decode and wait-state lookup; ROM is treated as unmapped while locked out.
    always_comb begin
        dec_region = REG_UNMAPPED;
        dec_ws     = 4'd0;
        if (VA[22:21] == 2'b00) begin
            if (!CE0) begin
                dec_region = REG_ROM;
                dec_ws     = ROM_WS_C;
            end
        end else if (VA[22:15] == 8'hA0) begin
            dec_region = REG_Z80;
            dec_ws     = Z80_WS_C;
        end else if (VA[22:15] == 8'hA1) begin
            dec_region = REG_IO;
            dec_ws     = IO_WS_C;
        end else if (VA[22:20] == 3'b111) begin
            dec_region = REG_RAM;
            dec_ws     = RAM_WS_C;
        end
    end

    // Next-state and next-output computation for the bus-cycle FSM.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        dtack_d    = dtack_q;
        active_d   = active_q;
        region_d   = region_q;
        timeout_d  = 1'b0;
`ifdef BUS_TIMEOUT_EN
        stall_cnt_d = stall_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                dtack_d = 1'b1;
                if (qualify) begin
                    region_d = dec_region;
                    active_d = 1'b1;
                    if (dec_region == REG_UNMAPPED) begin
                        state_d = ST_STALL;
`ifdef BUS_TIMEOUT_EN
                        stall_cnt_d = 7'd0;
`endif
                    end else begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = dec_ws;
                    end
                end
            end
            ST_WAIT: begin
                if (AS) begin
                    state_d  = ST_IDLE;
                    active_d = 1'b0;
                end else if (wait_cnt_q == 4'd0) begin
                    state_d = ST_ACK;
                    dtack_d = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                if (AS) begin
                    state_d  = ST_IDLE;
                    dtack_d  = 1'b1;
                    active_d = 1'b0;
                end
            end
            ST_STALL: begin
                if (AS) begin
                    state_d  = ST_IDLE;
                    active_d = 1'b0;
                end
`ifdef BUS_TIMEOUT_EN
                else if (stall_cnt_q == TIMEOUT_C) begin
                    state_d   = ST_ACK;
                    dtack_d   = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    stall_cnt_d = stall_cnt_q + 7'd1;
                end
`endif
            end
            default: begin
                state_d  = ST_IDLE;
                dtack_d  = 1'b1;
                active_d = 1'b0;
            end
        endcase
    end

    // State and output registers; SRES overrides every transition.
    always_ff @(posedge MCLK) begin
        if (SRES) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            dtack_q    <= 1'b1;
            active_q   <= 1'b0;
            region_q   <= REG_ROM;
            timeout_q  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            stall_cnt_q <= 7'd0;
`endif
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            dtack_q    <= dtack_d;
            active_q   <= active_d;
            region_q   <= region_d;
            timeout_q  <= timeout_d;
`ifdef BUS_TIMEOUT_EN
            stall_cnt_q <= stall_cnt_d;
`endif
        end
    end

    assign DTACK        = dtack_q;
    assign cycle_active = active_q;
    assign region       = region_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_bus_dtack_ctrl.sv
// Testbench for bus_dtack_ctrl: directed bus cycles, an edge-counting
// behavioural model compared every cycle, and literal spot checks.
module tb_bus_dtack_ctrl;

    localparam int ROM_WS  = 0;
    localparam int Z80_WS  = 2;
    localparam int IO_WS   = 1;
    localparam int RAM_WS  = 0;
    localparam int TIMEOUT = 127;
`ifdef BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        MCLK = 1'b0;
    logic        SRES = 1'b1;
    logic        AS   = 1'b1;
    logic        UDS  = 1'b1;
    logic        LDS  = 1'b1;
    logic        RW   = 1'b1;
    logic        CE0  = 1'b0;
    logic [22:0] VA   = 23'h0;
    logic        DTACK, cycle_active, timeout;
    logic [2:0]  region;

    int errors = 0;
    int checks = 0;
    int fail_prints = 0;
    bit chk_en = 1'b0;

    bus_dtack_ctrl #(
        .ROM_WS(ROM_WS), .Z80_WS(Z80_WS), .IO_WS(IO_WS),
        .RAM_WS(RAM_WS), .TIMEOUT(TIMEOUT)
    ) dut (
        .MCLK(MCLK), .SRES(SRES), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW),
        .VA(VA), .CE0(CE0), .DTACK(DTACK), .cycle_active(cycle_active),
        .region(region), .timeout(timeout)
    );

    always #5 MCLK = ~MCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (fail_prints < 40) begin
                fail_prints++;
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
            end
        end
    endtask

    // ---------------- behavioural model ----------------
    // Region from the byte address map; DTACK falls on an absolute edge number
    // computed at qualification, and rises on the first edge that samples AS high.
    function automatic int region_of(input logic [22:0] va, input logic ce0);
        logic [23:0] a;
        a = {va, 1'b0};
        if (a < 24'h400000) return ce0 ? 7 : 0;
        if (a >= 24'hA00000 && a < 24'hA10000) return 1;
        if (a >= 24'hA10000 && a < 24'hA20000) return 2;
        if (a >= 24'hE00000) return 3;
        return 7;
    endfunction

    function automatic int ws_of(input int r);
        case (r)
            0: return ROM_WS;
            1: return Z80_WS;
            2: return IO_WS;
            3: return RAM_WS;
            default: return 0;
        endcase
    endfunction

    int   n = 0;
    bit   busy = 1'b0;
    int   rel_edge = -1;
    int   mreg = 0;
    logic exp_dtack = 1'b1;
    logic exp_active = 1'b0;
    logic exp_to = 1'b0;
    logic [2:0] exp_region = 3'd0;

    always @(posedge MCLK) begin
        n++;
        exp_to = 1'b0;
        if (SRES) begin
            busy = 1'b0; exp_dtack = 1'b1; exp_active = 1'b0; exp_region = 3'd0;
        end else if (!busy) begin
            if (!AS && (!UDS || !LDS)) begin
                busy = 1'b1;
                mreg = region_of(VA, CE0);
                exp_region = 3'(mreg);
                exp_active = 1'b1;
                if (mreg != 7) rel_edge = n + ws_of(mreg) + 1;
                else rel_edge = TO_EN ? n + TIMEOUT + 1 : -1;
            end
        end else if (AS) begin
            busy = 1'b0; exp_active = 1'b0; exp_dtack = 1'b1;
        end else if (n == rel_edge) begin
            exp_dtack = 1'b0;
            exp_to = (mreg == 7);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge MCLK) begin
        if (chk_en) begin
            check("m_dtack",  DTACK,        exp_dtack);
            check("m_active", cycle_active, exp_active);
            check("m_region", region,       exp_region);
            check("m_timeout", timeout,     exp_to);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int k = 1);
        for (int i = 0; i < k; i++) begin
            @(posedge MCLK);
            #2;
        end
    endtask

    task automatic bus_idle();
        AS = 1'b1; UDS = 1'b1; LDS = 1'b1;
    endtask

    initial begin
        tick();
        check("rst_dtack", DTACK, 1);
        check("rst_active", cycle_active, 0);
        check("rst_region", region, 0);
        check("rst_timeout", timeout, 0);
        SRES = 1'b0;
        chk_en = 1'b1;
        tick(2);

        // ROM read, zero wait states
        VA = 23'h000100; CE0 = 1'b0; RW = 1'b1; AS = 1'b0; UDS = 1'b0; LDS = 1'b0;
        tick();
        check("rom_e0_active", cycle_active, 1);
        check("rom_e0_dtack", DTACK, 1);
        check("rom_region", region, 0);
        tick();
        check("rom_e1_dtack", DTACK, 0);
        tick();
        check("rom_hold_dtack", DTACK, 0);
        bus_idle();
        tick();
        check("rom_rel_dtack", DTACK, 1);
        check("rom_rel_active", cycle_active, 0);
        tick();

        // IO write: AS one clock before LDS; VA/CE0 changed after qualification
        VA = 23'h508000; RW = 1'b0; AS = 1'b0;
        tick();
        check("io_nostrobe_active", cycle_active, 0);
        LDS = 1'b0;
        tick();
        check("io_e0_active", cycle_active, 1);
        check("io_region", region, 2);
        VA = 23'h000000; CE0 = 1'b1;
        tick();
        check("io_e1_dtack", DTACK, 1);
        tick();
        check("io_e2_dtack", DTACK, 0);
        check("io_region_held", region, 2);
        bus_idle(); RW = 1'b1; CE0 = 1'b0;
        tick();
        check("io_rel_dtack", DTACK, 1);
        tick();

        // ROM read while locked out by TMSS
        VA = 23'h000100; CE0 = 1'b1; AS = 1'b0; UDS = 1'b0; LDS = 1'b0;
        tick();
        check("lock_region", region, 7);
        check("lock_e0_dtack", DTACK, 1);
        CE0 = 1'b0;
`ifdef BUS_TIMEOUT_EN
        tick(TIMEOUT);
        check("wd_pre_dtack", DTACK, 1);
        check("wd_pre_timeout", timeout, 0);
        tick();
        check("wd_dtack", DTACK, 0);
        check("wd_timeout", timeout, 1);
        tick();
        check("wd_pulse_end", timeout, 0);
        check("wd_dtack_hold", DTACK, 0);
`else
        tick(140);
        check("lock_dtack_held", DTACK, 1);
        check("lock_timeout", timeout, 0);
        check("lock_active", cycle_active, 1);
`endif
        bus_idle();
        tick();
        check("lock_rel_dtack", DTACK, 1);
        check("lock_rel_active", cycle_active, 0);
        check("lock_region_held", region, 7);
        tick();

        // Z80 read aborted during wait states
        VA = 23'h500000; AS = 1'b0; UDS = 1'b0;
        tick();
        check("z80_region", region, 1);
        tick();
        check("z80_e1_dtack", DTACK, 1);
        bus_idle();
        tick();
        check("z80_abort_active", cycle_active, 0);
        check("z80_abort_dtack", DTACK, 1);
        tick(3);
        check("z80_after_dtack", DTACK, 1);
        check("z80_after_timeout", timeout, 0);

        // SRES while acknowledging a RAM read
        VA = 23'h7F8000; AS = 1'b0; UDS = 1'b0; LDS = 1'b0;
        tick(2);
        check("sres_pre_dtack", DTACK, 0);
        check("sres_pre_region", region, 3);
        SRES = 1'b1;
        tick();
        check("sres_dtack", DTACK, 1);
        check("sres_active", cycle_active, 0);
        check("sres_region", region, 0);
        SRES = 1'b0; bus_idle();
        tick(2);

        // Back-to-back RAM reads with one AS-high sample between
        VA = 23'h7F8000; AS = 1'b0; UDS = 1'b0; LDS = 1'b0;
        tick();
        check("b2b_a_e0_dtack", DTACK, 1);
        tick();
        check("b2b_a_dtack", DTACK, 0);
        bus_idle();
        tick();
        check("b2b_gap_dtack", DTACK, 1);
        check("b2b_gap_active", cycle_active, 0);
        AS = 1'b0; UDS = 1'b0;
        tick();
        check("b2b_b_e0_active", cycle_active, 1);
        check("b2b_b_e0_dtack", DTACK, 1);
        tick();
        check("b2b_b_dtack", DTACK, 0);
        check("b2b_b_region", region, 3);
        bus_idle();
        tick(2);
        check("end_dtack", DTACK, 1);

        chk_en = 1'b0;
        @(negedge MCLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
